// File: rtl/boot_bist_seq.sv
// Power-on sequencer: holds the core in reset, runs memory BIST with bounded
// retries and a watchdog, requests firmware load, then releases the core.
module boot_bist_seq #(
   parameter int unsigned BIST_TIMEOUT = 4096,
   parameter int unsigned RETRY_MAX    = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   output logic       bist_start_o,
   input  logic       bist_test_i,
   input  logic       bist_go_i,
   output logic       fw_load_req_o,
   input  logic       fw_load_ack_i,
   output logic       core_rst_no,
   output logic       fetch_enable_o,
   output logic       pass_o,
   output logic       fail_o,
   output logic       timeout_o,
   output logic [2:0] retry_cnt_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_RUN   = 3'd2,
      S_COOL  = 3'd3,
      S_LOAD  = 3'd4,
      S_BOOT  = 3'd5,
      S_FAIL  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIST_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [2:0]       RETRY_LIM = 3'(RETRY_MAX);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       retry_d;
   logic             timeout_d;
   logic             retry_take;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retry_d    = retry_cnt_o;
      timeout_d  = timeout_o;
      retry_take = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               timeout_d  = 1'b1;
               retry_take = 1'b1;
            end else if (bist_test_i) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            // A verdict arriving on the last watchdog cycle still counts.
            if (!bist_test_i) begin
               if (bist_go_i) state_d = S_LOAD;
               else           retry_take = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               timeout_d  = 1'b1;
               retry_take = 1'b1;
            end
         end
         S_COOL: begin
            // The watchdog counter doubles as the two-cycle cool-down timer.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_ONE) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (fw_load_ack_i) state_d = S_BOOT;
         end
         default: ;
      endcase

      if (retry_take) begin
         if (retry_cnt_o < RETRY_LIM) begin
            state_d = S_COOL;
            retry_d = retry_cnt_o + 1'b1;
            cnt_d   = '0;
         end else begin
            state_d = S_FAIL;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         retry_cnt_o    <= '0;
         bist_start_o   <= 1'b0;
         fw_load_req_o  <= 1'b0;
         core_rst_no    <= 1'b0;
         fetch_enable_o <= 1'b0;
         pass_o         <= 1'b0;
         fail_o         <= 1'b0;
         timeout_o      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         retry_cnt_o    <= retry_d;
         timeout_o      <= timeout_d;
         bist_start_o   <= (state_d == S_START) || (state_d == S_RUN);
         fw_load_req_o  <= (state_d == S_LOAD);
         core_rst_no    <= (state_d == S_BOOT);
         fetch_enable_o <= (state_q == S_BOOT) && (state_d == S_BOOT);
         pass_o         <= pass_o || (state_d == S_BOOT);
         fail_o         <= fail_o || (state_d == S_FAIL);
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_boot_bist_seq.sv
// Randomized self-checking bench for boot_bist_seq; expected timing is derived
// from per-attempt arithmetic (rise/fall offsets against the watchdog window).
module tb_boot_bist_seq;

   localparam int T  = 16;
   localparam int RM = 1;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b1;
   logic       start_i = 1'b0;
   logic       bist_start_o;
   logic       bist_test_i = 1'b0;
   logic       bist_go_i = 1'b0;
   logic       fw_load_req_o;
   logic       fw_load_ack_i = 1'b0;
   logic       core_rst_no;
   logic       fetch_enable_o;
   logic       pass_o;
   logic       fail_o;
   logic       timeout_o;
   logic [2:0] retry_cnt_o;
   logic [2:0] state_o;

   boot_bist_seq #(.BIST_TIMEOUT(T), .RETRY_MAX(RM), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .bist_start_o(bist_start_o), .bist_test_i(bist_test_i), .bist_go_i(bist_go_i),
      .fw_load_req_o(fw_load_req_o), .fw_load_ack_i(fw_load_ack_i),
      .core_rst_no(core_rst_no), .fetch_enable_o(fetch_enable_o),
      .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
      .retry_cnt_o(retry_cnt_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;
   bit exp_to = 1'b0;
   int exp_ret = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Packs state, the seven 1-bit outputs and retry count into one word.
   task automatic check_outs(input string tag, input int st, input bit bs, input bit req,
                             input bit crst, input bit fe, input bit ps, input bit fl);
      logic [31:0] got, exp;
      got = {19'd0, state_o, bist_start_o, fw_load_req_o, core_rst_no, fetch_enable_o,
             pass_o, fail_o, timeout_o, retry_cnt_o};
      exp = {19'd0, 3'(st), bs, req, crst, fe, ps, fl, exp_to, 3'(exp_ret)};
      check(tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Asserts reset mid-cycle and checks outputs before any clock edge.
   task automatic apply_reset(input string tag);
      #2;
      rst_ni = 1'b0;
      start_i = 1'b0; bist_test_i = 1'b0; bist_go_i = 1'b0; fw_load_ack_i = 1'b0;
      #1;
      exp_to = 1'b0;
      exp_ret = 0;
      check_outs(tag, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic idle_phase(input int n);
      for (int i = 0; i < n; i++) begin
         start_i = 1'b0;
         bist_test_i = 1'($urandom);
         bist_go_i = 1'($urandom);
         fw_load_ack_i = 1'($urandom);
         tick();
         check_outs("idle", 0, 0, 0, 0, 0, 0, 0);
      end
      bist_test_i = 1'b0; fw_load_ack_i = 1'b0;
   endtask

   task automatic launch();
      start_i = 1'b1;
      bist_test_i = 1'b0;
      tick();
      start_i = 1'b0;
      check_outs("start", 1, 1, 0, 0, 0, 0, 0);
   endtask

   // One BIST attempt: busy sampled high on relative edges [r, r+d).
   // Result: 0 = went to LOAD, 1 = cooled and restarted, 2 = FAIL.
   task automatic attempt(input int r, input int d, input bit g, output int result);
      bit completed;
      int done;
      completed = (r + d <= T);
      done = completed ? r + d : T;
      for (int j = 1; j <= done; j++) begin
         bist_test_i = (j >= r) && (j < r + d);
         bist_go_i = (j == done && completed) ? g : 1'($urandom);
         fw_load_ack_i = 1'($urandom);
         start_i = 1'($urandom);
         tick();
         if (j < done) check_outs("bist", (j >= r) ? 2 : 1, 1, 0, 0, 0, 0, 0);
      end
      bist_test_i = 1'b0; fw_load_ack_i = 1'b0; start_i = 1'b0;
      if (!completed) exp_to = 1'b1;
      if (completed && g) begin
         result = 0;
         check_outs("to_load", 4, 0, 1, 0, 0, 0, 0);
      end else if (exp_ret < RM) begin
         result = 1;
         exp_ret++;
         check_outs("cool0", 3, 0, 0, 0, 0, 0, 0);
         tick();
         check_outs("cool1", 3, 0, 0, 0, 0, 0, 0);
         tick();
         check_outs("restart", 1, 1, 0, 0, 0, 0, 0);
      end else begin
         result = 2;
         check_outs("to_fail", 6, 0, 0, 0, 0, 0, 1);
         for (int i = 0; i < 5; i++) begin
            start_i = 1'($urandom); bist_test_i = 1'($urandom); fw_load_ack_i = 1'($urandom);
            tick();
            check_outs("fail_hold", 6, 0, 0, 0, 0, 0, 1);
         end
         start_i = 1'b0; bist_test_i = 1'b0; fw_load_ack_i = 1'b0;
      end
   endtask

   task automatic load_phase(input int a);
      for (int j = 1; j <= a; j++) begin
         fw_load_ack_i = (j == a);
         bist_test_i = 1'($urandom);
         bist_go_i = 1'($urandom);
         start_i = 1'($urandom);
         tick();
         if (j < a) check_outs("load_wait", 4, 0, 1, 0, 0, 0, 0);
      end
      fw_load_ack_i = 1'b0; bist_test_i = 1'b0; start_i = 1'b0;
      check_outs("boot0", 5, 0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         fw_load_ack_i = 1'($urandom); start_i = 1'($urandom);
         tick();
         check_outs("boot_run", 5, 0, 0, 1, 1, 1, 0);
      end
      fw_load_ack_i = 1'b0; start_i = 1'b0;
   endtask

   task automatic random_sequence();
      int res, mode, r, d;
      bit g;
      launch();
      res = 1;
      while (res == 1) begin
         mode = $urandom_range(4, 0);
         r = $urandom_range(4, 1);
         g = 1'b1;
         case (mode)
            0: d = $urandom_range(T - r, 1);
            1: begin d = $urandom_range(T - r, 1); g = 1'b0; end
            2: begin r = T + 100; d = 1; end
            3: d = T + 50;
            default: d = T - r;
         endcase
         attempt(r, d, g, res);
      end
      if (res == 0) load_phase($urandom_range(5, 1));
      apply_reset("rnd_rst");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int res;
      #2;
      apply_reset("por");

      idle_phase(100);

      // Nominal: busy rises 3 cycles in, runs 10, go=1, ack after 2.
      launch();
      attempt(3, 10, 1'b1, res);
      check("nominal_res", 32'(res), 32'd0);
      load_phase(2);
      apply_reset("rst_after_boot");

      // Retry exhaustion: two no-go verdicts.
      launch();
      attempt(2, 5, 1'b0, res);
      check("exh_first", 32'(res), 32'd1);
      attempt(2, 5, 1'b0, res);
      check("exh_second", 32'(res), 32'd2);
      apply_reset("rst_after_fail");

      // Watchdog on a stuck-low busy, then a passing retry.
      launch();
      attempt(T + 100, 1, 1'b0, res);
      check("wd_first", 32'(res), 32'd1);
      attempt(2, 4, 1'b1, res);
      check("wd_second", 32'(res), 32'd0);
      load_phase(1);
      apply_reset("rst_after_wd");

      // Tie: verdict lands on the last watchdog cycle.
      launch();
      attempt(3, T - 3, 1'b1, res);
      check("tie_res", 32'(res), 32'd0);
      load_phase(3);
      apply_reset("rst_after_tie");

      // Asynchronous reset mid-RUN, then a clean resequence.
      launch();
      for (int j = 1; j <= 3; j++) begin
         bist_test_i = 1'b1;
         tick();
         check_outs("pre_abort_run", 2, 1, 0, 0, 0, 0, 0);
      end
      apply_reset("abort_run");
      launch();
      attempt(1, 6, 1'b1, res);
      load_phase(2);
      apply_reset("rst_reseq1");

      // Asynchronous reset mid-LOAD, then a clean resequence.
      launch();
      attempt(2, 3, 1'b1, res);
      tick();
      check_outs("pre_abort_load", 4, 0, 1, 0, 0, 0, 0);
      apply_reset("abort_load");
      idle_phase(4);
      launch();
      attempt(4, 8, 1'b1, res);
      load_phase(4);
      apply_reset("rst_reseq2");

      for (int n = 0; n < 30; n++) begin
         idle_phase($urandom_range(3, 1));
         random_sequence();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/boot_bist_seq.md
# boot_bist_seq

Power-on sequencer sitting between the top-level clock/reset and the RI5CY wrapper. Holds the core in reset with fetch disabled, launches the memory BIST, evaluates its go/no-go verdict with bounded retries and a watchdog, then requests firmware load and releases the core. Replaces the ad-hoc BIST/firmware sequencing currently done by testbench code with synthesizable control.

## Interface
- `BIST_TIMEOUT`, 4096: max cycles spent in START+RUN per attempt (>=2).
- `RETRY_MAX`, 2: extra BIST attempts after first failure (0..7).
- `CNT_W`, 16: timeout counter width; must hold BIST_TIMEOUT-1.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  level; begin sequence when high in IDLE.
- `bist_start_o`  out  1  BIST start request (drives BIST `start_test`).
- `bist_test_i`  in  1  BIST busy (`test_o`): high while running, low when done.
- `bist_go_i`  in  1  BIST verdict (`go_nogo`), valid when `bist_test_i` falls.
- `fw_load_req_o`  out  1  firmware load request, held until acked.
- `fw_load_ack_i`  in  1  firmware load complete.
- `core_rst_no`  out  1  core reset, active-low.
- `fetch_enable_o`  out  1  core fetch enable.
- `pass_o`  out  1  sticky: sequence completed, core released.
- `fail_o`  out  1  sticky: BIST failed after all retries.
- `timeout_o`  out  1  sticky: at least one attempt hit the watchdog.
- `retry_cnt_o`  out  3  retries consumed.
- `state_o`  out  3  current state encoding.

## Operation
- States/encoding: IDLE=0, START=1, RUN=2, COOL=3, LOAD=4, BOOT=5, FAIL=6. All outputs registered.
- IDLE: `start_i`=1 -> START; else stay.
- START: `bist_start_o`=1; wait for `bist_test_i`=1 -> RUN.
- RUN: `bist_start_o`=1; on `bist_test_i`=0 sample `bist_go_i`: 1 -> LOAD; 0 -> retry path.
- Watchdog: counter cleared on entry to START, +1 each cycle in START/RUN; counter==BIST_TIMEOUT-1 without completion that cycle -> set `timeout_o`, take retry path. Completion in the same cycle wins over timeout.
- Retry path: `retry_cnt_o`<RETRY_MAX -> COOL, `retry_cnt_o`+1; else -> FAIL.
- COOL: `bist_start_o`=0 for exactly 2 cycles, then START.
- LOAD: `fw_load_req_o`=1 until `fw_load_ack_i` sampled 1 -> BOOT. No watchdog in LOAD.
- BOOT: `core_rst_no`=1, `pass_o`=1; `fetch_enable_o`=1 from the cycle after entry. Terminal until reset.
- FAIL: `fail_o`=1, core held in reset, fetch disabled, `bist_start_o`=0. Terminal until reset.
- `start_i` ignored outside IDLE; `fw_load_ack_i` ignored outside LOAD; `bist_go_i` ignored except at RUN exit.

## Timing
- Reset values: state IDLE; `bist_start_o`, `fw_load_req_o`, `core_rst_no`, `fetch_enable_o`, `pass_o`, `fail_o`, `timeout_o` = 0; `retry_cnt_o`=0; counter=0.
- `start_i` sampled high at edge k -> `bist_start_o`=1 after edge k.
- `bist_test_i` fall sampled at edge k -> `bist_start_o`=0 and `fw_load_req_o`=1 (pass) after edge k.
- Ack sampled at edge k -> `fw_load_req_o`=0, `core_rst_no`=1 after k; `fetch_enable_o`=1 after k+1.
- Timeout: START entered at edge k with `bist_test_i` stuck 0 -> retry path taken at edge k+BIST_TIMEOUT.
- `rst_ni` low at any time, including mid-RUN/LOAD: all outputs to reset values immediately (asynchronous), core forced back into reset; restart needs `start_i`.

## Test plan
- Nominal: start=1, `bist_test_i` rises 3 cycles later, falls 10 cycles later with go=1, ack 2 cycles later -> `core_rst_no`=1, `fetch_enable_o`=1 next cycle, `pass_o`=1, `retry_cnt_o`=0.
- Retry exhaustion, RETRY_MAX=1: two no-go verdicts -> COOL 2 cycles with `bist_start_o`=0, `retry_cnt_o`=1, then FAIL, `fail_o`=1, `core_rst_no`=0 forever.
- Watchdog, BIST_TIMEOUT=16: `bist_test_i` held 0 -> retry path exactly 16 cycles after START entry, `timeout_o`=1; second attempt passes -> BOOT with `timeout_o` still 1.
- Tie: `bist_test_i` falls with go=1 on counter==15 (BIST_TIMEOUT=16) -> LOAD, `timeout_o`=0.
- Reset mid-RUN and mid-LOAD -> all outputs reset values same cycle, `state_o`=0, `retry_cnt_o`=0; resequence passes normally.
- `start_i`=0 for 100 cycles -> state IDLE, `bist_start_o`=0; stray `fw_load_ack_i`/`bist_test_i` pulses cause no transition.
